// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared FSM encoding, size codes and lane helpers for mem_bridge
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam int TIMEOUT_DEFAULT = 255;

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: lane_enables = 4'b1000 >> offset;
      SZ_HALF: lane_enables = offset[1] ? 4'b0011 : 4'b1100;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_WORD: access_legal = (offset == 2'b00);
      SZ_HALF: access_legal = ~offset[0];
      SZ_BYTE: access_legal = 1'b1;
      default: access_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: replicate_store = {4{wdata[7:0]}};
      SZ_HALF: replicate_store = {2{wdata[15:0]}};
      default: replicate_store = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_load_align.sv
// rtl/mem_bridge_load_align.sv - selects the addressed load lane and sign/zero-extends it
module mem_bridge_load_align
  import mem_bridge_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    data      = rdata;
    case (offset)
      2'd0:    byte_lane = rdata[31:24];
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
    case (size)
      SZ_BYTE: data = {{24{sign & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{sign & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - CPU load/store to single-port memory bridge with alignment, lanes and timeout
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sign,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic        wr_q, sign_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [7:0]  cnt_q;
  logic        in_access, req_legal, timeout_hit;
  logic [31:0] load_data;

  assign in_access   = (state == ST_ACCESS);
  assign req_legal   = access_legal(cpu_size, cpu_addr[1:0]);
  assign timeout_hit = ((cnt_q + 8'd1) == TIMEOUT_CNT);

  mem_bridge_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .sign   (sign_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cpu_req) state_nxt = req_legal ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (mem_ack || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // An ack arriving on the final counted cycle still wins over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= SZ_WORD;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            wr_q    <= cpu_wr;
            sign_q  <= cpu_sign;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            size_q  <= cpu_size;
            err_q   <= ~req_legal;
            rdata_q <= '0;
            cnt_q   <= '0;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            rdata_q <= wr_q ? 32'h0 : load_data;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_done  = (state == ST_RESP);
  assign cpu_err   = cpu_done & err_q;
  assign cpu_rdata = cpu_done ? rdata_q : 32'h0;
  assign cpu_stall = rst_n & cpu_req & ~cpu_done;

  assign mem_req   = in_access;
  assign mem_we    = in_access & wr_q;
  assign mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be    = in_access ? lane_enables(size_q, addr_q[1:0]) : 4'b0000;
  assign mem_wdata = in_access ? replicate_store(size_q, wdata_q) : 32'h0;

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed scoreboard bench for mem_bridge
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wr, cpu_sign;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_size  (cpu_size),
    .cpu_sign  (cpu_sign),
    .cpu_stall (cpu_stall),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ack_dly: index of the ACCESS cycle in which mem_ack is driven, -1 = never.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sign, input int ack_dly,
                        input logic [31:0] mrd, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_mem, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input int exp_lat);
    int   cyc;
    int   acc;
    logic done_seen;
    logic mem_seen;
    exp_t e;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    cpu_size = size; cpu_sign = sign;
    cyc = 0; acc = 0; done_seen = 1'b0; mem_seen = 1'b0;
    while (!done_seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (mem_req) begin
        mem_seen = 1'b1;
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
        check("mem_we", {31'h0, mem_we}, {31'h0, wr});
        check("mem_wdata", mem_wdata, exp_wdata);
        mem_ack   = (acc == ack_dly);
        mem_rdata = mrd;
        acc++;
      end
      if (cpu_done) begin
        done_seen = 1'b1;
        n_tests++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_empty: observed done with %0d queued expected >0", sb.size());
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("cpu_rdata", cpu_rdata, e.rdata);
          check("cpu_err", {31'h0, cpu_err}, {31'h0, e.err});
        end
        check("latency", cyc, exp_lat);
        check("stall_at_done", {31'h0, cpu_stall}, 32'h0);
        cpu_req = 1'b0;
      end else begin
        check("stall_pending", {31'h0, cpu_stall}, 32'h1);
      end
    end
    check("done_seen", {31'h0, done_seen}, 32'h1);
    check("mem_seen", {31'h0, mem_seen}, {31'h0, exp_mem});
    @(negedge clk);
    mem_ack = 1'b0;
    check("done_one_cycle", {31'h0, cpu_done}, 32'h0);
    check("idle_mem_req", {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_size = SZ_WORD; cpu_sign = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_cpu_done", {31'h0, cpu_done}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // wr addr wdata size sign ack_dly mrd | exp_rdata err mem addr be wdata lat
    access(0, 32'h100, 0, SZ_WORD, 0, 0, 32'h11223344, 32'h11223344, 0, 1, 32'h100, 4'b1111, 32'h0, 2);
    access(0, 32'h103, 0, SZ_BYTE, 1, 0, 32'h000000F0, 32'hFFFFFFF0, 0, 1, 32'h100, 4'b0001, 32'h0, 2);
    access(0, 32'h103, 0, SZ_BYTE, 0, 0, 32'h000000F0, 32'h000000F0, 0, 1, 32'h100, 4'b0001, 32'h0, 2);
    access(1, 32'h102, 32'h0000ABCD, SZ_HALF, 0, 2, 32'h0, 32'h0, 0, 1, 32'h100, 4'b0011, 32'hABCDABCD, 4);
    access(0, 32'h101, 0, SZ_HALF, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0000, 32'h0, 1);
    access(0, 32'h102, 0, SZ_WORD, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0000, 32'h0, 1);
    access(0, 32'h100, 0, SZ_ILLEGAL, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0000, 32'h0, 1);
    access(0, 32'h104, 0, SZ_WORD, 0, -1, 32'h55555555, 32'h0, 1, 1, 32'h104, 4'b1111, 32'h0, 5);
    access(0, 32'h108, 0, SZ_WORD, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 32'h108, 4'b1111, 32'h0, 5);
    access(0, 32'h200, 0, SZ_BYTE, 1, 0, 32'h80112233, 32'hFFFFFF80, 0, 1, 32'h200, 4'b1000, 32'h0, 2);
    access(0, 32'h204, 0, SZ_HALF, 1, 1, 32'h80017777, 32'hFFFF8001, 0, 1, 32'h204, 4'b1100, 32'h0, 3);
    access(0, 32'h206, 0, SZ_HALF, 0, 0, 32'h1234F00D, 32'h0000F00D, 0, 1, 32'h204, 4'b0011, 32'h0, 2);
    access(1, 32'h301, 32'hFFFFFF5A, SZ_BYTE, 0, 0, 32'h0, 32'h0, 0, 1, 32'h300, 4'b0100, 32'h5A5A5A5A, 2);
    access(1, 32'h400, 32'h12345678, SZ_WORD, 0, 1, 32'h0, 32'h0, 0, 1, 32'h400, 4'b1111, 32'h12345678, 3);

    // Stray ack while idle must not produce a completion.
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    check("stray_ack_done", {31'h0, cpu_done}, 32'h0);
    check("stray_ack_req", {31'h0, mem_req}, 32'h0);

    // Reset during ACCESS aborts immediately.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h200; cpu_size = SZ_WORD; cpu_sign = 1'b0;
    @(negedge clk);
    check("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_req", {31'h0, mem_req}, 32'h0);
    check("abort_stall", {31'h0, cpu_stall}, 32'h0);
    check("abort_mem_be", {28'h0, mem_be}, 32'h0);
    check("abort_done", {31'h0, cpu_done}, 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    access(0, 32'h100, 0, SZ_WORD, 0, 0, 32'hCAFEBABE, 32'hCAFEBABE, 0, 1, 32'h100, 4'b1111, 32'h0, 2);

    check("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
